// File: rtl/pipeline_hazard_ctrl_pkg.sv
// ============================================================================
// pipeline_hazard_ctrl_pkg : shared state encodings and MDU latency limits
// Rev 1.0
// ============================================================================
`default_nettype none

package pipeline_hazard_ctrl_pkg;

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_MDU_BUSY = 1'b1
  } state_e;

  localparam int MDU_LAT_MIN = 2;
  localparam int MDU_LAT_MAX = 16;
  localparam int X0_IDX      = 0;

  // Width needed to hold MDU_LAT-1 down to zero.
  function automatic int mdu_cnt_w(input int lat);
    return $clog2(lat + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_mdu_wait_counter.sv
// ============================================================================
// mdu_wait_counter : load/decrement/hold down-counter with last-cycle flag
// Rev 1.0
// ============================================================================
`default_nettype none

module mdu_wait_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         last_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last_o = (count_q == W'(1));

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
// pipeline_hazard_ctrl : 5-stage pipeline stall/flush sequencer
// Optional perf counters built when PIPE_PERF_EN is defined.  Rev 1.0
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_W   = 5,
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs1_i,
  input  logic [REG_W-1:0] id_rs2_i,
  input  logic             id_use_rs1_i,
  input  logic             id_use_rs2_i,
  input  logic [REG_W-1:0] ex_rd_i,
  input  logic             ex_is_load_i,
  input  logic             ex_redirect_i,
  input  logic             ex_mdu_start_i,
  input  logic             imem_ready_i,
  input  logic             mem_dmem_req_i,
  input  logic             dmem_ready_i,
  output logic             pc_ce_o,
  output logic             ifid_ce_o,
  output logic             ifid_rst_o,
  output logic             idex_ce_o,
  output logic             idex_rst_o,
  output logic             exmem_ce_o,
  output logic             exmem_rst_o,
  output logic             memwb_ce_o,
  output logic             memwb_rst_o,
  output logic             mdu_busy_o,
  output logic [CNT_W-1:0] perf_stall_cnt_o,
  output logic [CNT_W-1:0] perf_flush_cnt_o
);

  localparam int MC_W = mdu_cnt_w(MDU_LAT);

  state_e state_q;
  logic   w_dmem_wait;
  logic   w_load_use;
  logic   w_mdu_load;
  logic   w_mdu_dec;
  logic   w_mdu_last;
  logic   w_flush;

  assign w_dmem_wait = mem_dmem_req_i & ~dmem_ready_i;
  assign w_load_use  = ex_is_load_i && (ex_rd_i != REG_W'(X0_IDX)) &&
                       ((id_use_rs1_i && (id_rs1_i == ex_rd_i)) ||
                        (id_use_rs2_i && (id_rs2_i == ex_rd_i)));
  assign w_mdu_load  = (state_q == ST_RUN) && ex_mdu_start_i && !w_dmem_wait;
  assign w_mdu_dec   = (state_q == ST_MDU_BUSY) && !w_dmem_wait;

  mdu_wait_counter #(
    .W (MC_W)
  ) u_mdu_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (w_mdu_load),
    .load_val_i (MC_W'(MDU_LAT - 1)),
    .dec_i      (w_mdu_dec),
    .last_o     (w_mdu_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else if (w_mdu_load) begin
      state_q <= ST_MDU_BUSY;
    end else if (w_mdu_dec && w_mdu_last) begin
      state_q <= ST_RUN;
    end
  end

  always_comb begin
    pc_ce_o     = 1'b1;
    ifid_ce_o   = 1'b1;
    ifid_rst_o  = 1'b0;
    idex_ce_o   = 1'b1;
    idex_rst_o  = 1'b0;
    exmem_ce_o  = 1'b1;
    exmem_rst_o = 1'b0;
    memwb_ce_o  = 1'b1;
    memwb_rst_o = 1'b0;
    w_flush     = 1'b0;
    mdu_busy_o  = (state_q == ST_MDU_BUSY) || ex_mdu_start_i;
    if (rst) begin
      pc_ce_o     = 1'b0;
      ifid_ce_o   = 1'b0;
      ifid_rst_o  = 1'b1;
      idex_ce_o   = 1'b0;
      idex_rst_o  = 1'b1;
      exmem_ce_o  = 1'b0;
      exmem_rst_o = 1'b1;
      memwb_ce_o  = 1'b0;
      memwb_rst_o = 1'b1;
      mdu_busy_o  = 1'b0;
    end else if (w_dmem_wait) begin
      pc_ce_o     = 1'b0;
      ifid_ce_o   = 1'b0;
      idex_ce_o   = 1'b0;
      exmem_ce_o  = 1'b0;
      memwb_ce_o  = 1'b0;
      memwb_rst_o = 1'b1;
    end else if ((state_q == ST_MDU_BUSY) || ex_mdu_start_i) begin
      // Start cycle and every busy cycle hold the front end; only the final
      // busy cycle lets the MDU result into EX/MEM.
      pc_ce_o   = 1'b0;
      ifid_ce_o = 1'b0;
      idex_ce_o = 1'b0;
      if ((state_q == ST_MDU_BUSY) && w_mdu_last) begin
        exmem_ce_o  = 1'b1;
      end else begin
        exmem_ce_o  = 1'b0;
        exmem_rst_o = 1'b1;
      end
    end else if (ex_redirect_i) begin
      ifid_rst_o = 1'b1;
      idex_rst_o = 1'b1;
      w_flush    = 1'b1;
    end else if (w_load_use) begin
      pc_ce_o    = 1'b0;
      ifid_ce_o  = 1'b0;
      idex_rst_o = 1'b1;
    end else if (!imem_ready_i) begin
      pc_ce_o    = 1'b0;
      ifid_rst_o = 1'b1;
    end
  end

`ifdef PIPE_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!pc_ce_o) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (w_flush)  flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign perf_stall_cnt_o = stall_cnt_q;
  assign perf_flush_cnt_o = flush_cnt_q;
`else
  assign perf_stall_cnt_o = '0;
  assign perf_flush_cnt_o = '0;
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(ex_redirect_i && ex_mdu_start_i));
    end
  end
`endif

endmodule

`default_nettype wire
